// File: rtl/lock_sequencer.sv
// Code-entry controller: detects key presses, checks them against a stored code and
// sequences unlock, failed-entry error pulses and lockout.
module lock_sequencer #(
  parameter int unsigned                         N_KEYS      = 4,
  parameter int unsigned                         CODE_LEN    = 4,
  parameter logic [CODE_LEN*$clog2(N_KEYS)-1:0]  CODE        = 8'h1B,
  parameter int unsigned                         MAX_FAIL    = 3,
  parameter int unsigned                         UNLOCK_CYC  = 500,
  parameter int unsigned                         LOCKOUT_CYC = 1000,
  parameter int unsigned                         TIMEOUT_CYC = 2000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_KEYS-1:0]                key_sync,
  output logic                             unlock,
  output logic                             lockout,
  output logic                             err,
  output logic [$clog2(CODE_LEN+1)-1:0]    digit_cnt,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

  localparam int unsigned KW   = $clog2(N_KEYS);
  localparam int unsigned DW   = $clog2(CODE_LEN + 1);
  localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMAX = (UNLOCK_CYC > LOCKOUT_CYC) ?
                                 ((UNLOCK_CYC > TIMEOUT_CYC) ? UNLOCK_CYC : TIMEOUT_CYC) :
                                 ((LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_CYC - 1);
  localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [DW-1:0] DIGIT_LAST   = DW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FAIL_LAST    = FW'(MAX_FAIL - 1);
  localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_FAIL);

  typedef enum logic [1:0] {ST_ENTRY, ST_OPEN, ST_LOCKOUT} state_e;

  state_e            state_q, state_d;
  logic [N_KEYS-1:0] key_prev_q;
  logic              mismatch_q, mismatch_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DW-1:0]     digit_cnt_q, digit_cnt_d;
  logic [FW-1:0]     fail_cnt_q, fail_cnt_d;
  logic              unlock_q, unlock_d;
  logic              lockout_q, lockout_d;
  logic              err_q, err_d;

  logic [N_KEYS-1:0] rise;
  logic              press;
  logic              multi;
  logic [KW-1:0]     digit;
  logic [KW-1:0]     exp_digit;
  logic              miss;

  always_comb begin
    rise      = key_sync & ~key_prev_q;
    press     = |rise;
    multi     = press && !$onehot(rise);
    digit     = '0;
    exp_digit = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (rise[i]) digit = KW'(i);
    end
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (digit_cnt_q == DW'(i)) exp_digit = CODE[i*KW +: KW];
    end
    miss = mismatch_q | multi | (digit != exp_digit);
  end

  always_comb begin
    state_d     = state_q;
    mismatch_d  = mismatch_q;
    timer_d     = timer_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    unlock_d    = unlock_q;
    lockout_d   = lockout_q;
    err_d       = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (press) begin
          timer_d = '0;
          if (digit_cnt_q == DIGIT_LAST) begin
            digit_cnt_d = '0;
            mismatch_d  = 1'b0;
            if (!miss) begin
              state_d    = ST_OPEN;
              unlock_d   = 1'b1;
              fail_cnt_d = '0;
            end else if (fail_cnt_q == FAIL_LAST) begin
              state_d    = ST_LOCKOUT;
              lockout_d  = 1'b1;
              err_d      = 1'b1;
              fail_cnt_d = FAIL_MAX;
            end else begin
              err_d      = 1'b1;
              fail_cnt_d = fail_cnt_q + 1'b1;
            end
          end else begin
            digit_cnt_d = digit_cnt_q + 1'b1;
            mismatch_d  = miss;
          end
        end else if (digit_cnt_q != '0) begin
          // Abandoned partial entry: silently discarded, failure count untouched.
          if (timer_q == TIMEOUT_LAST) begin
            timer_d     = '0;
            digit_cnt_d = '0;
            mismatch_d  = 1'b0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_OPEN: begin
        if (timer_q == UNLOCK_LAST) begin
          state_d  = ST_ENTRY;
          unlock_d = 1'b0;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == LOCKOUT_LAST) begin
          state_d    = ST_ENTRY;
          lockout_d  = 1'b0;
          fail_cnt_d = '0;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ENTRY;
      key_prev_q  <= '0;
      mismatch_q  <= 1'b0;
      timer_q     <= '0;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
      unlock_q    <= 1'b0;
      lockout_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_prev_q  <= key_sync;
      mismatch_q  <= mismatch_d;
      timer_q     <= timer_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      unlock_q    <= unlock_d;
      lockout_q   <= lockout_d;
      err_q       <= err_d;
    end
  end

  assign unlock    = unlock_q;
  assign lockout   = lockout_q;
  assign err       = err_q;
  assign digit_cnt = digit_cnt_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed self-checking bench for lock_sequencer; code is 0,1,2,3 (digit 0 in LSBs).
module tb_lock_sequencer;

  localparam logic [7:0] CODE_TB = 8'hE4;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_sync;
  logic       unlock;
  logic       lockout;
  logic       err;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;

  int checks;
  int errors;
  int err_pulses;

  lock_sequencer #(
    .N_KEYS      (4),
    .CODE_LEN    (4),
    .CODE        (CODE_TB),
    .MAX_FAIL    (3),
    .UNLOCK_CYC  (500),
    .LOCKOUT_CYC (1000),
    .TIMEOUT_CYC (2000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_sync  (key_sync),
    .unlock    (unlock),
    .lockout   (lockout),
    .err       (err),
    .digit_cnt (digit_cnt),
    .fail_cnt  (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (err === 1'b1) err_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int unsigned k);
    key_sync    = '0;
    key_sync[k] = 1'b1;
    tick();
    key_sync    = '0;
    tick();
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    key_sync = '0;
    tick(2);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    key_sync = '0;
    tick(2);
    checks++;
    if ({unlock, lockout, err, digit_cnt, fail_cnt} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: actual=%b required=%b",
               {unlock, lockout, err, digit_cnt, fail_cnt}, 8'h00);
    end
    #2 rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_unlock();
    int base;
    base = err_pulses;
    for (int unsigned i = 0; i < 3; i++) begin
      key_sync = 4'b0001 << i;
      tick();
      checks++;
      if (digit_cnt !== 3'(i + 1)) begin
        errors++;
        $display("FAIL unlock_digit_cnt: actual=%0d required=%0d", digit_cnt, i + 1);
      end
      key_sync = '0;
      tick(9);
    end
    key_sync = 4'b1000;
    tick();
    checks++;
    if ({unlock, fail_cnt, digit_cnt} !== {1'b1, 2'd0, 3'd0}) begin
      errors++;
      $display("FAIL unlock_rise: actual=%b required=%b", {unlock, fail_cnt, digit_cnt}, 6'b100000);
    end
    key_sync = '0;
    tick(100);
    press(0);
    tick(397);
    checks++;
    if (unlock !== 1'b1) begin
      errors++;
      $display("FAIL unlock_last_cycle: actual=%b required=1", unlock);
    end
    tick();
    checks++;
    if ({unlock, digit_cnt} !== 4'b0000) begin
      errors++;
      $display("FAIL unlock_exit: actual=%b required=0000", {unlock, digit_cnt});
    end
    checks++;
    if (err_pulses - base !== 0) begin
      errors++;
      $display("FAIL unlock_no_err: actual=%0d required=0", err_pulses - base);
    end
  endtask

  task automatic test_wrong_code();
    press(0);
    press(1);
    press(3);
    key_sync = 4'b1000;
    tick();
    checks++;
    if ({err, unlock, fail_cnt, digit_cnt} !== {1'b1, 1'b0, 2'd1, 3'd0}) begin
      errors++;
      $display("FAIL wrong_code: actual=%b required=%b", {err, unlock, fail_cnt, digit_cnt}, 7'b1001000);
    end
    key_sync = '0;
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL wrong_err_width: actual=%b required=0", err);
    end
  endtask

  task automatic test_lockout();
    int base;
    int n;
    apply_reset();
    base = err_pulses;
    for (int unsigned e = 0; e < 3; e++) begin
      press(0);
      press(0);
      press(0);
      key_sync = 4'b0001;
      tick();
      checks++;
      if ({err, lockout, fail_cnt} !== {1'b1, (e == 2), 2'(e + 1)}) begin
        errors++;
        $display("FAIL lockout_entry%0d: actual=%b required=%b", e,
                 {err, lockout, fail_cnt}, {1'b1, (e == 2), 2'(e + 1)});
      end
      key_sync = '0;
      tick();
    end
    n = 1;
    press(0);
    press(1);
    press(2);
    press(3);
    n += 8;
    checks++;
    if ({unlock, lockout, digit_cnt, err} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL lockout_ignores_keys: actual=%b required=%b",
               {unlock, lockout, digit_cnt, err}, 6'b010000);
    end
    tick(986);
    key_sync = 4'b0001;
    tick(4);
    checks++;
    if ({lockout, fail_cnt} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL lockout_last_cycle: actual=%b required=%b", {lockout, fail_cnt}, 3'b111);
    end
    tick();
    checks++;
    if ({lockout, fail_cnt, err} !== 4'b0000) begin
      errors++;
      $display("FAIL lockout_exit: actual=%b required=0000", {lockout, fail_cnt, err});
    end
    tick(5);
    checks++;
    if (digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL lockout_held_key: actual=%0d required=0", digit_cnt);
    end
    key_sync = '0;
    tick();
    checks++;
    if (err_pulses - base !== 3) begin
      errors++;
      $display("FAIL lockout_err_count: actual=%0d required=3", err_pulses - base);
    end
  endtask

  task automatic test_multi_rise();
    key_sync = 4'b0110;
    tick();
    checks++;
    if (digit_cnt !== 3'd1) begin
      errors++;
      $display("FAIL multi_counts_one: actual=%0d required=1", digit_cnt);
    end
    key_sync = '0;
    tick();
    press(1);
    press(2);
    key_sync = 4'b1000;
    tick();
    checks++;
    if ({err, unlock, fail_cnt} !== {1'b1, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL multi_forced_miss: actual=%b required=%b", {err, unlock, fail_cnt}, 4'b1001);
    end
    key_sync = '0;
    tick();
  endtask

  task automatic test_timeout();
    int base;
    base = err_pulses;
    press(0);
    press(1);
    tick(1998);
    checks++;
    if (digit_cnt !== 3'd2) begin
      errors++;
      $display("FAIL timeout_early: actual=%0d required=2", digit_cnt);
    end
    tick();
    checks++;
    if ({digit_cnt, fail_cnt} !== {3'd0, 2'd1}) begin
      errors++;
      $display("FAIL timeout_clear: actual=%b required=%b", {digit_cnt, fail_cnt}, 5'b00001);
    end
    checks++;
    if (err_pulses - base !== 0) begin
      errors++;
      $display("FAIL timeout_no_err: actual=%0d required=0", err_pulses - base);
    end
    key_sync = 4'b0001;
    tick(50);
    checks++;
    if (digit_cnt !== 3'd1) begin
      errors++;
      $display("FAIL held_key_one_digit: actual=%0d required=1", digit_cnt);
    end
    key_sync = '0;
    tick();
    press(1);
    press(2);
    key_sync = 4'b1000;
    tick();
    checks++;
    if ({unlock, fail_cnt} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL timeout_then_unlock: actual=%b required=100", {unlock, fail_cnt});
    end
    key_sync = '0;
  endtask

  task automatic test_reset_in_open();
    int base;
    base = err_pulses;
    tick(199);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({unlock, lockout, err, digit_cnt, fail_cnt} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_open: actual=%b required=%b",
               {unlock, lockout, err, digit_cnt, fail_cnt}, 8'h00);
    end
    tick(2);
    #2 rst_n = 1'b1;
    tick(3);
    checks++;
    if ({unlock, digit_cnt, fail_cnt, err_pulses - base} !== {1'b0, 3'd0, 2'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_release_state: actual=%b required=0", {unlock, digit_cnt, fail_cnt});
    end
    press(0);
    press(1);
    press(2);
    key_sync = 4'b1000;
    tick();
    checks++;
    if (unlock !== 1'b1) begin
      errors++;
      $display("FAIL entry_after_reset: actual=%b required=1", unlock);
    end
    key_sync = '0;
    tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    err_pulses = 0;
    rst_n      = 1'b0;
    key_sync   = '0;
    test_reset();
    test_unlock();
    test_wrong_code();
    test_lockout();
    test_multi_rise();
    test_timeout();
    test_reset_in_open();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
